// File: rtl/lcd_fb_arbiter.sv
// Framebuffer RAM arbiter: real-time scanout reads take the single RAM port,
// and pixel writes wait in a small FIFO until a cycle with no scan request.
module lcd_fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              in_9mhz_clk,
  input  logic              in_rst,
  input  logic              in_scan_req,
  input  logic [ADDR_W-1:0] in_scan_addr,
  output logic              out_scan_valid,
  output logic [DATA_W-1:0] out_scan_data,
  input  logic              in_wr_valid,
  input  logic [ADDR_W-1:0] in_wr_addr,
  input  logic [DATA_W-1:0] in_wr_data,
  output logic              out_wr_ready,
  output logic              out_wr_ovf,
  input  logic              in_ovf_clr,
  output logic [15:0]       out_stall_cnt,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_we,
  output logic [DATA_W-1:0] out_mem_wdata,
  input  logic [DATA_W-1:0] in_mem_rdata
);

  localparam int PTR_W   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    GRANT_IDLE,
    GRANT_SCAN,
    GRANT_WRITE
  } grant_t;

  logic [ENTRY_W-1:0] fifo_mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]  mem_wdata_reg, mem_wdata_next;
  logic               mem_we_reg, mem_we_next;

  logic               scan_pend_reg;
  logic               scan_valid_reg;
  logic [DATA_W-1:0]  scan_data_reg;
  logic               ovf_reg;
  logic [15:0]        stall_cnt_reg;

  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] fifo_head;
  grant_t             grant;

  // Readiness comes only from registered occupancy, so a pop in a full cycle
  // never opens room for a push in that same cycle.
  assign fifo_empty   = (count_reg == '0);
  assign fifo_full    = (count_reg == CNT_W'(FIFO_DEPTH));
  assign push         = in_wr_valid & ~fifo_full;
  assign fifo_head    = fifo_mem_reg[rd_ptr_reg];

  always_comb begin
    grant = GRANT_IDLE;
    if (in_scan_req) begin
      grant = GRANT_SCAN;
    end else if (!fifo_empty) begin
      grant = GRANT_WRITE;
    end
  end

  assign pop = (grant == GRANT_WRITE);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_we_next    = 1'b0;
    case (grant)
      GRANT_SCAN: begin
        mem_addr_next = in_scan_addr;
      end
      GRANT_WRITE: begin
        mem_addr_next  = fifo_head[ENTRY_W-1:DATA_W];
        mem_wdata_next = fifo_head[DATA_W-1:0];
        mem_we_next    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Entry storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge in_9mhz_clk) begin
    if (push) begin
      fifo_mem_reg[wr_ptr_reg] <= {in_wr_addr, in_wr_data};
    end
  end

  always_ff @(posedge in_9mhz_clk or posedge in_rst) begin
    if (in_rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_we_reg    <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_we_reg    <= mem_we_next;
    end
  end

  // Scan return path: the address sits on the RAM port for one cycle, then
  // the read word is captured, giving a fixed two-cycle latency.
  always_ff @(posedge in_9mhz_clk or posedge in_rst) begin
    if (in_rst) begin
      scan_pend_reg  <= 1'b0;
      scan_valid_reg <= 1'b0;
      scan_data_reg  <= '0;
    end else begin
      scan_pend_reg  <= in_scan_req;
      scan_valid_reg <= scan_pend_reg;
      if (scan_pend_reg) begin
        scan_data_reg <= in_mem_rdata;
      end
    end
  end

  always_ff @(posedge in_9mhz_clk or posedge in_rst) begin
    if (in_rst) begin
      ovf_reg       <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      if (in_wr_valid && fifo_full) begin
        ovf_reg <= 1'b1;
      end else if (in_ovf_clr) begin
        ovf_reg <= 1'b0;
      end
      if (!fifo_empty && in_scan_req && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

  assign out_wr_ready   = ~fifo_full;
  assign out_wr_ovf     = ovf_reg;
  assign out_stall_cnt  = stall_cnt_reg;
  assign out_mem_addr   = mem_addr_reg;
  assign out_mem_we     = mem_we_reg;
  assign out_mem_wdata  = mem_wdata_reg;
  assign out_scan_valid = scan_valid_reg;
  assign out_scan_data  = scan_data_reg;

endmodule

// File: doc/lcd_fb_arbiter.md
LCD_FB_ARBITER -- requirements
Module: lcd_fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, framebuffer word address width (480x272 = 130560 words).
REQ-002 SHALL have parameter DATA_W, default 16, pixel width (RGB565).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, write FIFO entries; power of two, minimum 2.
REQ-004 in_9mhz_clk  input  1  sole clock; all state on its rising edge.
REQ-005 in_rst  input  1  reset, asynchronous, active-high.
REQ-006 in_scan_req  input  1  scanout read request, real-time, one word per asserted cycle.
REQ-007 in_scan_addr  input  ADDR_W  scanout read address, sampled with in_scan_req.
REQ-008 out_scan_valid  output  1  out_scan_data holds the word for a request issued 2 cycles earlier.
REQ-009 out_scan_data  output  DATA_W  scanout read data.
REQ-010 in_wr_valid  input  1  writer offers a pixel write.
REQ-011 in_wr_addr  input  ADDR_W  write address.
REQ-012 in_wr_data  input  DATA_W  write data.
REQ-013 out_wr_ready  output  1  write FIFO can accept; transfer when in_wr_valid and out_wr_ready both high.
REQ-014 out_wr_ovf  output  1  sticky: in_wr_valid seen while out_wr_ready low.
REQ-015 in_ovf_clr  input  1  clears out_wr_ovf.
REQ-016 out_stall_cnt  output  16  saturating count of cycles a pending write lost to scanout.
REQ-017 out_mem_addr  output  ADDR_W  single-port RAM address, registered.
REQ-018 out_mem_we  output  1  RAM write enable, registered.
REQ-019 out_mem_wdata  output  DATA_W  RAM write data, registered.
REQ-020 in_mem_rdata  input  DATA_W  RAM read data, valid 1 cycle after a read address is presented.

Function
REQ-021 Each cycle, grant SHALL be: SCAN if in_scan_req; else WRITE if FIFO non-empty; else IDLE.
REQ-022 Scanout SHALL have absolute priority; a scan request is never delayed or dropped.
REQ-023 SCAN grant: next edge out_mem_addr<=in_scan_addr, out_mem_we<=0.
REQ-024 WRITE grant: next edge out_mem_addr/out_mem_wdata<=FIFO head, out_mem_we<=1, head popped same edge.
REQ-025 IDLE grant: next edge out_mem_we<=0; out_mem_addr and out_mem_wdata hold.
REQ-026 Scan pipeline: request at cycle N -> RAM address at N+1 -> out_scan_data<=in_mem_rdata and out_scan_valid=1 at N+2; fixed latency 2, no bubbles.
REQ-027 out_scan_valid SHALL be 0 in every cycle not 2 after a scan request.
REQ-028 FIFO SHALL be first-in first-out; writes reach RAM in acceptance order.
REQ-029 out_wr_ready SHALL equal NOT full, from registered occupancy only; a same-cycle pop does not admit a push when full.
REQ-030 Push and pop in the same cycle when neither full nor empty: occupancy unchanged, both take effect.
REQ-031 A write accepted into an empty FIFO at cycle N SHALL reach out_mem_we at N+2 earliest (FIFO registered, then grant).
REQ-032 Read/write same address: scan read returns RAM contents at its own address cycle; no forwarding from FIFO.
REQ-033 out_wr_ovf SHALL set on in_wr_valid with out_wr_ready low; in_ovf_clr clears; simultaneous set and clear -> set wins.
REQ-034 out_stall_cnt SHALL increment when FIFO non-empty and in_scan_req high; saturate at 16'hFFFF; cleared only by reset.
REQ-035 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter range 0..FIFO_DEPTH.

Reset
REQ-036 in_rst high SHALL immediately clear: FIFO (empty), out_wr_ready=1, out_mem_we=0, out_mem_addr=0, out_mem_wdata=0, out_scan_valid=0, out_scan_data=0, out_wr_ovf=0, out_stall_cnt=0.
REQ-037 Reset mid-operation SHALL discard buffered writes and in-flight scan reads; no out_mem_we pulse after reset asserts.
REQ-038 First grant after reset release SHALL occur on the first rising edge with in_rst low.

Verification
REQ-039 Scan burst addr 0..479, no writes -> out_mem_addr 0..479 from cycle 1, out_scan_valid 480 consecutive cycles from cycle 2, data matches RAM model.
REQ-040 Write 4 words (addr 0x100..0x103) with scan idle -> out_mem_we 4 pulses in order, first at acceptance+2, out_wr_ready stays 1.
REQ-041 Hold in_scan_req high, push 5 writes -> out_wr_ready low after 4th, 5th raises out_wr_ovf, out_stall_cnt increments every cycle; drop scan -> 4 writes drain in order.
REQ-042 out_wr_ovf set, pulse in_ovf_clr with in_wr_valid low -> ovf 0; repeat with full FIFO and in_wr_valid high -> ovf stays 1.
REQ-043 Assert in_rst asynchronously with 3 writes queued and 2 scan reads in flight -> all REQ-036 values immediately, no further out_mem_we or out_scan_valid.
REQ-044 Force stall 65540 cycles -> out_stall_cnt saturates at 16'hFFFF, does not wrap.
